// File: rtl/share_mem_pkg.sv
// Shared definitions for both ends of the inter-CPU message ring in share_mem.
// Port-B addresses are {REGION_PREFIX, word[9:0]}. CPU A owns words 0x000-0x1FF.
// CPU B owns words 0x200-0x3FF.
package share_mem_pkg;

  localparam logic [21:0] CPU_A_REGION_LO = 22'h002000;
  localparam logic [21:0] CPU_A_REGION_HI = 22'h0021FF;
  localparam logic [21:0] CPU_B_REGION_LO = 22'h002200;
  localparam logic [21:0] CPU_B_REGION_HI = 22'h0023FF;

  localparam logic [11:0] REGION_PREFIX = 12'h008;

  localparam logic [9:0] DEF_HEAD_ADDR = 10'h1FF;
  localparam logic [9:0] DEF_TAIL_ADDR = 10'h3FF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POLL,
    ST_HCAP,
    ST_RD,
    ST_DCAP,
    ST_HOLD,
    ST_WB,
    ST_GAP
  } ring_rd_state_e;

  // Map a 10-bit word address onto the port-B byte-region address.
  function automatic logic [21:0] region_addr(input logic [9:0] word);
    return {REGION_PREFIX, word};
  endfunction

endpackage

// File: rtl/share_mem_ring_reader.sv
// Consumer end of the CPU A -> CPU B message ring in shared memory.
// The block polls the head index and streams new words out on valid/ready.
// It publishes its tail index once at the end of each batch.
// RING_DEPTH must be a power of two no larger than 511. POLL_GAP must be at least 1.
module share_mem_ring_reader
  import share_mem_pkg::*;
#(
  parameter logic [9:0] RING_BASE  = 10'h000,
  parameter int         RING_DEPTH = 256,
  parameter logic [9:0] HEAD_ADDR  = DEF_HEAD_ADDR,
  parameter logic [9:0] TAIL_ADDR  = DEF_TAIL_ADDR,
  parameter int         POLL_GAP   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic [21:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] dout_data,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        ring_empty,
  output logic        head_err
);

  localparam int IDX_W = $clog2(RING_DEPTH);
  localparam int GAP_W = $clog2(POLL_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(POLL_GAP - 1);
  localparam logic [31:0]      DEPTH_W32 = 32'(RING_DEPTH);
  // The tail writeback must land in the CPU B region. A misconfigured TAIL_ADDR never writes.
  localparam logic TAIL_IN_B = (region_addr(TAIL_ADDR) >= CPU_B_REGION_LO) &&
                               (region_addr(TAIL_ADDR) <= CPU_B_REGION_HI);

  ring_rd_state_e   state, state_nxt;
  logic [IDX_W-1:0] tail, head_snap, tail_inc, rd_head;
  logic [GAP_W-1:0] gap_cnt;
  logic             head_oob;

  assign tail_inc = tail + IDX_W'(1);
  assign rd_head  = mem_rdata[IDX_W-1:0];
  assign head_oob = (mem_rdata >= DEPTH_W32);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and memory strobes. The strobes depend on state only, so reset clears them at once.
  always_comb begin
    state_nxt = state;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state)
      ST_IDLE: if (enable) state_nxt = ST_POLL;
      ST_POLL: begin
        mem_re    = 1'b1;
        mem_addr  = region_addr(HEAD_ADDR);
        state_nxt = ST_HCAP;
      end
      ST_HCAP: begin
        if (head_oob || (rd_head == tail)) state_nxt = ST_GAP;
        else                               state_nxt = ST_RD;
      end
      ST_RD: begin
        mem_re    = 1'b1;
        mem_addr  = region_addr(RING_BASE + 10'(tail));
        state_nxt = ST_DCAP;
      end
      ST_DCAP: state_nxt = ST_HOLD;
      ST_HOLD: begin
        // A held word always completes its handshake. Enable only stops the batch after that.
        if (dout_ready) begin
          if ((tail_inc != head_snap) && enable) state_nxt = ST_RD;
          else                                   state_nxt = ST_WB;
        end
      end
      ST_WB: begin
        mem_we    = TAIL_IN_B;
        mem_addr  = region_addr(TAIL_ADDR);
        mem_wdata = 32'(tail);
        state_nxt = enable ? ST_GAP : ST_IDLE;
      end
      ST_GAP: begin
        if (!enable)                  state_nxt = ST_IDLE;
        else if (gap_cnt == GAP_LAST) state_nxt = ST_POLL;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Ring indices and status flags: capture head on HCAP, advance tail on each accepted word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tail       <= '0;
      head_snap  <= '0;
      ring_empty <= 1'b1;
      head_err   <= 1'b0;
    end else begin
      if (state == ST_HCAP) begin
        if (head_oob) begin
          head_err   <= 1'b1;
          ring_empty <= 1'b1;
        end else begin
          head_snap  <= rd_head;
          ring_empty <= (rd_head == tail);
        end
      end
      if ((state == ST_HOLD) && dout_ready) tail <= tail_inc;
    end
  end

  // Output word register: loaded from the RAM on DCAP and held until accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_data  <= '0;
      dout_valid <= 1'b0;
    end else if (state == ST_DCAP) begin
      dout_data  <= mem_rdata;
      dout_valid <= 1'b1;
    end else if ((state == ST_HOLD) && dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

  // Poll-gap counter: runs only while in GAP and restarts from zero on every entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              gap_cnt <= '0;
    else if (state == ST_GAP) gap_cnt <= gap_cnt + GAP_W'(1);
    else                     gap_cnt <= '0;
  end

endmodule
